funct_generator_fifo: RTL
=========================

Name: funct_generator_fifo

Overview:
- Synchronous single-clock FIFO that directly consumes the function generator's sample stream: the generator's write-enable and data outputs connect to wr_en_i/data_i.
- Buffers signed fixed-point samples for a downstream reader (DAC/UART/host interface) that pops on rd_en_i.
- Provides full/empty/almost-full status, an occupancy count and sticky overflow/underflow error flags so dropped samples are observable.

Parameters:
- DATA_WIDTH, 32, sample width; matches the generator output width.
- ADDR_WIDTH, 4, pointer width; depth = 2**ADDR_WIDTH (16 entries).
- AF_THRESH, 12, almost_full_o asserts when count_o >= AF_THRESH; legal range 1..2**ADDR_WIDTH.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous active-low reset; sampled on posedge clk.
- wr_en_i  input  1  write request, one sample per cycle.
- data_i  input  DATA_WIDTH  signed write sample.
- rd_en_i  input  1  read request (pop).
- clrh_err_i  input  1  synchronous clear of the sticky error flags, active-high.
- data_o  output  DATA_WIDTH  signed registered read data.
- valid_o  output  1  single-cycle pulse: data_o holds a newly popped sample.
- full_o  output  1  count_o == 2**ADDR_WIDTH.
- empty_o  output  1  count_o == 0.
- almost_full_o  output  1  count_o >= AF_THRESH.
- count_o  output  ADDR_WIDTH+1  current occupancy, 0..2**ADDR_WIDTH.
- overflow_o  output  1  sticky: a write was dropped.
- underflow_o  output  1  sticky: a read was rejected.

Behaviour:
- Reset (rst==0 at posedge): wr_ptr=0, rd_ptr=0, count_o=0, data_o=0, valid_o=0, overflow_o=0, underflow_o=0; empty_o=1, full_o=0, almost_full_o=0. Memory contents are not reset. Reset has priority over all other inputs, including mid-burst.
- Storage: 2**ADDR_WIDTH x DATA_WIDTH register array. Pointers are ADDR_WIDTH bits and wrap naturally from 2**ADDR_WIDTH-1 to 0.
- Status flags full_o, empty_o and almost_full_o are combinational decodes of the registered count_o; no extra latency.
- Read acceptance: rd_acc = rd_en_i && !empty_o. Empty is evaluated before any same-cycle write, so there is no fall-through.
- Write acceptance: wr_acc = wr_en_i && (!full_o || rd_acc). At full, a write in the same cycle as an accepted read is allowed.
- On wr_acc: mem[wr_ptr] <= data_i; wr_ptr <= wr_ptr+1.
- On rd_acc: data_o <= mem[rd_ptr]; rd_ptr <= rd_ptr+1; valid_o <= 1 for exactly one cycle.
- When no read is accepted: valid_o <= 0 and data_o holds its value.
- Read latency: data_o/valid_o are valid on the cycle after rd_en_i is sampled with empty_o==0.
- Count update: count_o <= count_o + wr_acc - rd_acc. A simultaneous accepted read and write leaves the count unchanged.
- Overflow: wr_en_i && full_o && !rd_acc. The sample is dropped, pointers and memory are untouched, and overflow_o <= 1.
- Underflow: rd_en_i && empty_o. No pop occurs, data_o holds, valid_o=0, and underflow_o <= 1. A same-cycle write is still accepted.
- Error clear: clrh_err_i clears both sticky flags next cycle. If an error event occurs in the same cycle, set wins (flag stays 1).
- Sample data is stored bit-exact; the signed value is never altered.
- Continuous streaming: with wr_en_i and rd_en_i both high every cycle, throughput is 1 sample/cycle at any occupancy >= 1.

Test Plan:
- Reset then idle -> empty_o=1, full_o=0, count_o=0, data_o=0, valid_o=0, both error flags 0.
- Write 3 samples 0x10000000, 0xF0000000, 0x7FFFFFFF, then 3 reads -> valid_o pulses one cycle after each rd_en_i; data_o returns the same values in order; count_o goes 3,2,1,0; empty_o=1 at the end.
- Write 16 samples 0..15 -> full_o=1, almost_full_o=1 from count_o=12. A 17th write (0xAA) -> overflow_o=1, count_o stays 16. Draining returns 0..15, with no 0xAA.
- With the FIFO full, drive rd_en_i and wr_en_i (0x55) together -> count_o stays 16, no overflow. After draining 15 samples, the last read returns 0x55; pointers have wrapped correctly.
- On empty, drive rd_en_i and wr_en_i (0x22) together -> underflow_o=1, valid_o=0, count_o=1. The next read returns 0x22. Then clrh_err_i=1 clears the flags, except when asserted in the same cycle as a new underflow, in which case underflow_o stays 1.
- Fill 8 samples, then assert rst=0 for one cycle mid-stream -> all outputs return to reset values. The first write/read pair after reset returns the new sample, not stale data.

Source files
------------

// File: rtl/funct_generator_fifo.sv
`default_nettype none
// ============================================================================
// Module      : funct_generator_fifo
// Description : Single-clock sample FIFO between the function generator and a
//               downstream reader. Registered read data with a one-cycle
//               valid pulse, occupancy count, full/empty/almost-full status
//               and sticky overflow/underflow flags.
// Revision    : 1.0 - initial release
// ============================================================================
module funct_generator_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_THRESH  = 12
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en_i,
  input  logic signed [DATA_WIDTH-1:0] data_i,
  input  logic                         rd_en_i,
  input  logic                         clrh_err_i,
  output logic signed [DATA_WIDTH-1:0] data_o,
  output logic                         valid_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic                         almost_full_o,
  output logic [ADDR_WIDTH:0]          count_o,
  output logic                         overflow_o,
  output logic                         underflow_o
);

  localparam int                c_depth    = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] c_full_cnt = (ADDR_WIDTH + 1)'(c_depth);
  localparam logic [ADDR_WIDTH:0] c_af_cnt   = (ADDR_WIDTH + 1)'(AF_THRESH);

  logic signed [DATA_WIDTH-1:0] r_mem [c_depth];
  logic [ADDR_WIDTH-1:0]        r_wr_ptr;
  logic [ADDR_WIDTH-1:0]        r_rd_ptr;
  logic [ADDR_WIDTH:0]          r_count;
  logic signed [DATA_WIDTH-1:0] r_data;
  logic                         r_valid;
  logic                         r_overflow;
  logic                         r_underflow;

  logic w_full;
  logic w_empty;
  logic w_rd_acc;
  logic w_wr_acc;
  logic w_ovf_evt;
  logic w_unf_evt;

  // Status flags decode straight from the registered count: no added latency.
  assign w_full  = (r_count == c_full_cnt);
  assign w_empty = (r_count == '0);

  // Empty is judged before any same-cycle write, so a write never falls
  // through to the read port. A full FIFO still takes a write when a read
  // frees a slot in the same cycle.
  assign w_rd_acc  = rd_en_i && !w_empty;
  assign w_wr_acc  = wr_en_i && (!w_full || w_rd_acc);
  assign w_ovf_evt = wr_en_i && w_full && !w_rd_acc;
  assign w_unf_evt = rd_en_i && w_empty;

  // Sample storage; deliberately not reset, only written on accepted writes.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= data_i;
    end
  end

  // Pointers, occupancy and read port; reset has priority over everything.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
      end
      if (w_rd_acc) begin
        r_data   <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
        r_valid  <= 1'b1;
      end else begin
        r_valid  <= 1'b0;
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + (ADDR_WIDTH + 1)'(1);
        2'b01:   r_count <= r_count - (ADDR_WIDTH + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky error flags; a new error event beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_ovf_evt) begin
        r_overflow <= 1'b1;
      end else if (clrh_err_i) begin
        r_overflow <= 1'b0;
      end
      if (w_unf_evt) begin
        r_underflow <= 1'b1;
      end else if (clrh_err_i) begin
        r_underflow <= 1'b0;
      end
    end
  end

  assign data_o        = r_data;
  assign valid_o       = r_valid;
  assign full_o        = w_full;
  assign empty_o       = w_empty;
  assign almost_full_o = (r_count >= c_af_cnt);
  assign count_o       = r_count;
  assign overflow_o    = r_overflow;
  assign underflow_o   = r_underflow;

endmodule
`default_nettype wire
